icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller instruction port. It serves `imemREN`/`imemaddr` requests from the datapath, returning `ihit`/`imemload`. On a miss it fills a two-word block from memory with `iREN`/`iaddr`/`iwait`/`iload`. It holds no dirty state and never writes memory.

## Interface
- `SETS`, default 8: number of sets; a power of two ≥ 2. Index width is `IW = log2(SETS)`; tag width is `30 - 1 - IW`.
- `CLK` (in, 1): clock; all state updates on the rising edge.
- `nRST` (in, 1): reset, asynchronous, active-low.
- `imemREN` (in, 1): fetch request from the datapath.
- `imemaddr` (in, 32): fetch byte address; bits [1:0] are always 00.
- `ihit` (out, 1): the requested word is valid on `imemload` this cycle.
- `imemload` (out, 32): fetched instruction word.
- `iREN` (out, 1): memory read request.
- `iaddr` (out, 32): memory read word address.
- `iwait` (in, 1): memory busy. When low while `iREN` is high, `iload` is valid this cycle.
- `iload` (in, 32): memory read data.

## Operation
- **Address split.** [1:0] is the byte offset and is ignored. [2] selects the word within the block. [2+IW:3] is the index. [31:3+IW] is the tag.
- **Per-set storage.** Each set holds `valid` (1 bit), `tag`, `word0` and `word1`.
- **States.** The FSM has three states: IDLE, FILL0 and FILL1.
- **IDLE.**
  - `hit` = `valid[idx]` && `tag[idx] == addr tag`.
  - `ihit` = `imemREN && hit`, produced combinationally.
  - `imemload` = `word1[idx]` if addr[2] else `word0[idx]`.
  - When `imemREN && !hit`:
    - Latch `{tag, idx}` into `miss_addr`.
    - Clear `valid[idx]`.
    - Go to FILL0.
- **FILL0.**
  - `iREN` = 1.
  - `iaddr` = `{miss_addr, 1'b0, 2'b00}`.
  - When `iwait` = 0: write `iload` into `word0[miss idx]` and go to FILL1.
- **FILL1.**
  - `iREN` = 1.
  - `iaddr` = `{miss_addr, 1'b1, 2'b00}`.
  - When `iwait` = 0:
    - Write `iload` into `word1`.
    - Write the tag, and set `valid` = 1.
    - Go to IDLE.
- **During FILL0/FILL1.**
  - `ihit` = 0, even if the current `imemaddr` hits another set. The cache is blocking.
  - A change to `imemaddr` does not affect the fill, nor does `imemREN` going low. The fill always completes for `miss_addr`.
- **In IDLE.** `iREN` = 0 and `iaddr` = 0.
- **Output value rules.**
  - `imemload` is only meaningful while `ihit` = 1.
  - It is 0 whenever `imemREN` = 0.
- **Reset (any state, including mid-fill).**
  - All `valid` bits are cleared and the state goes to IDLE.
  - `iREN` = 0, `iaddr` = 0, `ihit` = 0 and `imemload` = 0.
  - The interrupted fill is abandoned, and no partial block becomes valid.
- **Eviction.** A miss to a valid set with a different tag is a conflict miss. It overwrites that set in place.

## Timing
- **Hit.** Zero-cycle latency: `ihit` is asserted in the same cycle the address is presented.
- **Miss, zero-wait memory** (miss presented in cycle 0):
  - Cycle 1: FILL0, `iREN` high.
  - Cycle 2: FILL1.
  - Cycle 3: IDLE, `ihit` = 1 for the same address.
- **Miss latency in general.** `3 + W0 + W1` cycles, where `W0` and `W1` are the numbers of `iwait`-high cycles in FILL0 and FILL1.
- **Address stability.** `iaddr` is stable from FILL0 entry until the `iwait`-low cycle of that state.
- **Update timing.** Array writes and state transitions take effect at the rising edge that ends the `iwait`-low cycle.
- **Registered vs combinational.** `iREN` and `iaddr` are decoded from the state register alone, so they carry no combinational path from `imemaddr`. `ihit` and `imemload` are combinational from `imemaddr`.

## Test plan
- **Cold miss, zero-wait.**
  - Stimulus: reset, then `imemREN` = 1, `imemaddr` = 0x0000_0000. Memory returns 0x2001_0005 for 0x0 and 0x2002_0007 for 0x4, with `iwait` = 0.
  - Required: `iREN` is high in cycles 1–2 with `iaddr` = 0x0 then 0x4. `ihit` = 1 with `imemload` = 0x2001_0005 in cycle 3.
  - Follow-up: then `imemaddr` = 0x4 gives an immediate `ihit` with 0x2002_0007.
- **Wait states.**
  - Stimulus: miss to 0x0000_0040 with `iwait` held high for 4 cycles in FILL0 and 2 cycles in FILL1.
  - Required: `iaddr` stays at 0x40 for 5 cycles, then 0x44 for 3 cycles. `ihit` rises in cycle 9.
- **Conflict eviction.**
  - Stimulus: with `SETS` = 8, fill 0x0000_0000, then access 0x0000_0040 (same index, new tag).
  - Required: miss and refill. A subsequent access to 0x0 misses again.
- **Address change mid-fill.**
  - Stimulus: miss on 0x0000_0008; during FILL0 switch `imemaddr` to 0x0000_0010 and drop `imemREN` for one cycle.
  - Required: the fill still fetches 0x8 and 0xC. Afterwards 0x10 misses, and 0x8 hits.
- **Reset mid-fill.**
  - Stimulus: assert `nRST` = 0 while in FILL1.
  - Required: `iREN` drops to 0 asynchronously. After release, 0x0 misses (`valid` is cleared).
- **Hit during other activity.**
  - Stimulus: after filling sets 0–7, sweep addresses 0x0–0x3C with `imemREN` = 1.
  - Required: `ihit` = 1 every cycle and `iREN` = 0 throughout.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with two-word blocks.
// Hits are served combinationally; misses run a blocking two-beat fill from memory.
module icache #(
    parameter int SETS = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [1:0]  dbg_state_o
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 29 - IW;

    typedef enum logic [1:0] {IDLE, FILL0, FILL1} state_t;

    state_t          state_q;
    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q   [SETS];
    logic [31:0]     word0_q [SETS];
    logic [31:0]     word1_q [SETS];
    logic [28:0]     miss_addr_q;
    logic            iren_q;
    logic [31:0]     iaddr_q;

    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic [IW-1:0]   miss_idx;
    logic            hit;
    logic            unused_byte_off;

    assign idx             = imemaddr[2+IW:3];
    assign tag             = imemaddr[31:3+IW];
    assign miss_idx        = miss_addr_q[IW-1:0];
    assign unused_byte_off = ^imemaddr[1:0];

    // Only IDLE can hit, which keeps the cache blocking while a fill is in flight.
    assign hit      = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    assign ihit     = imemREN && hit;
    assign imemload = ihit ? (imemaddr[2] ? word1_q[idx] : word0_q[idx]) : 32'h0;

    assign iREN        = iren_q;
    assign iaddr       = iaddr_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            iren_q      <= 1'b0;
            iaddr_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_addr_q  <= {tag, idx};
                        valid_q[idx] <= 1'b0;
                        iren_q       <= 1'b1;
                        iaddr_q      <= {tag, idx, 3'b000};
                        state_q      <= FILL0;
                    end
                end
                FILL0: begin
                    if (!iwait) begin
                        iaddr_q <= {miss_addr_q, 3'b100};
                        state_q <= FILL1;
                    end
                end
                FILL1: begin
                    if (!iwait) begin
                        valid_q[miss_idx] <= 1'b1;
                        iren_q            <= 1'b0;
                        iaddr_q           <= 32'h0;
                        state_q           <= IDLE;
                    end
                end
                default: begin
                    iren_q  <= 1'b0;
                    iaddr_q <= 32'h0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays need no reset: valid_q alone decides whether a set is usable.
    always_ff @(posedge CLK) begin
        if (state_q == FILL0 && !iwait) begin
            word0_q[miss_idx] <= iload;
        end
        if (state_q == FILL1 && !iwait) begin
            word1_q[miss_idx] <= iload;
            tag_q[miss_idx]   <= miss_addr_q[28:IW];
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, wait states, eviction, mid-fill address change,
// reset during a fill, and a full hit sweep.
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [1:0]  dbg_state;

    int tests_run;
    int tests_failed;

    icache #(.SETS(8)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .dbg_state_o(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: two fixed words at 0x0/0x4, every other word is 0xC0DE0000 | addr.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_data = 32'h2001_0005;
            32'h0000_0004: mem_data = 32'h2002_0007;
            default:       mem_data = 32'hC0DE_0000 | a;
        endcase
    endfunction

    assign iload = mem_data(iaddr);

    // One cycle: drive inputs on the falling edge, let combinational outputs settle.
    task automatic step(input logic ren, input logic [31:0] addr, input logic w);
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = w;
        #1;
    endtask

    task automatic test_reset;
        tests_run++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: iREN=%b iaddr=%h, expected 0 / 00000000", iREN, iaddr);
        end
        tests_run++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_hit: ihit=%b imemload=%h, expected 0 / 00000000", ihit, imemload);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_cold_miss;
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            tests_failed++;
            $display("FAIL cold_c0: ihit=%b iREN=%b, expected 0 / 0", ihit, iREN);
        end
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (iREN !== 1'b1 || iaddr !== 32'h0 || ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL cold_c1: iREN=%b iaddr=%h ihit=%b, expected 1 / 00000000 / 0", iREN, iaddr, ihit);
        end
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (iREN !== 1'b1 || iaddr !== 32'h4) begin
            tests_failed++;
            $display("FAIL cold_c2: iREN=%b iaddr=%h, expected 1 / 00000004", iREN, iaddr);
        end
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'h2001_0005 || iREN !== 1'b0 || iaddr !== 32'h0) begin
            tests_failed++;
            $display("FAIL cold_c3: ihit=%b imemload=%h iREN=%b iaddr=%h, expected 1 / 20010005 / 0 / 00000000",
                     ihit, imemload, iREN, iaddr);
        end
        step(1'b1, 32'h4, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'h2002_0007) begin
            tests_failed++;
            $display("FAIL cold_word1: ihit=%b imemload=%h, expected 1 / 20020007", ihit, imemload);
        end
        step(1'b0, 32'h4, 1'b0);
        tests_run++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            tests_failed++;
            $display("FAIL cold_noren: ihit=%b imemload=%h, expected 0 / 00000000", ihit, imemload);
        end
    endtask

    task automatic test_wait_states;
        step(1'b1, 32'h40, 1'b1);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_miss: ihit=%b, expected 0", ihit);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 32'h40, (i < 5));
            tests_run++;
            if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait_fill0_c%0d: iREN=%b iaddr=%h ihit=%b, expected 1 / 00000040 / 0", i, iREN, iaddr, ihit);
            end
        end
        for (int i = 6; i <= 8; i++) begin
            step(1'b1, 32'h40, (i < 8));
            tests_run++;
            if (iREN !== 1'b1 || iaddr !== 32'h44 || ihit !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait_fill1_c%0d: iREN=%b iaddr=%h ihit=%b, expected 1 / 00000044 / 0", i, iREN, iaddr, ihit);
            end
        end
        step(1'b1, 32'h40, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_0040 || iREN !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_c9: ihit=%b imemload=%h iREN=%b, expected 1 / c0de0040 / 0", ihit, imemload, iREN);
        end
        step(1'b1, 32'h44, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_0044) begin
            tests_failed++;
            $display("FAIL wait_word1: ihit=%b imemload=%h, expected 1 / c0de0044", ihit, imemload);
        end
    endtask

    task automatic test_conflict;
        // Set 0 now holds 0x40; 0x0 shares the index with a different tag.
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_0_miss: ihit=%b, expected 0", ihit);
        end
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin
            tests_failed++;
            $display("FAIL conflict_0_refill: ihit=%b imemload=%h, expected 1 / 20010005", ihit, imemload);
        end
        step(1'b1, 32'h40, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_40_miss: ihit=%b, expected 0", ihit);
        end
        step(1'b1, 32'h40, 1'b0);
        step(1'b1, 32'h40, 1'b0);
        step(1'b1, 32'h40, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_0040) begin
            tests_failed++;
            $display("FAIL conflict_40_refill: ihit=%b imemload=%h, expected 1 / c0de0040", ihit, imemload);
        end
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_0_again: ihit=%b, expected 0", ihit);
        end
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_addr_change;
        step(1'b1, 32'h8, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL chg_miss: ihit=%b, expected 0", ihit);
        end
        step(1'b0, 32'h10, 1'b0);
        tests_run++;
        if (iREN !== 1'b1 || iaddr !== 32'h8 || ihit !== 1'b0 || imemload !== 32'h0) begin
            tests_failed++;
            $display("FAIL chg_fill0: iREN=%b iaddr=%h ihit=%b imemload=%h, expected 1 / 00000008 / 0 / 00000000",
                     iREN, iaddr, ihit, imemload);
        end
        // 0x0 is resident, yet a blocking cache must not hit during a fill.
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (iREN !== 1'b1 || iaddr !== 32'hC || ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL chg_fill1: iREN=%b iaddr=%h ihit=%b, expected 1 / 0000000c / 0", iREN, iaddr, ihit);
        end
        step(1'b1, 32'h10, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL chg_10_miss: ihit=%b, expected 0", ihit);
        end
        step(1'b1, 32'h10, 1'b0);
        step(1'b1, 32'h10, 1'b0);
        step(1'b1, 32'h8, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_0008) begin
            tests_failed++;
            $display("FAIL chg_8_hit: ihit=%b imemload=%h, expected 1 / c0de0008", ihit, imemload);
        end
        step(1'b1, 32'hC, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_000C) begin
            tests_failed++;
            $display("FAIL chg_c_hit: ihit=%b imemload=%h, expected 1 / c0de000c", ihit, imemload);
        end
        step(1'b1, 32'h10, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_0010) begin
            tests_failed++;
            $display("FAIL chg_10_hit: ihit=%b imemload=%h, expected 1 / c0de0010", ihit, imemload);
        end
    endtask

    task automatic test_reset_mid_fill;
        step(1'b1, 32'h18, 1'b0);
        step(1'b1, 32'h18, 1'b0);
        step(1'b1, 32'h18, 1'b1);
        tests_run++;
        if (iREN !== 1'b1 || iaddr !== 32'h1C) begin
            tests_failed++;
            $display("FAIL rst_pre: iREN=%b iaddr=%h, expected 1 / 0000001c", iREN, iaddr);
        end
        #1 nRST = 1'b0;
        #1;
        tests_run++;
        if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0 || imemload !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_async: iREN=%b iaddr=%h ihit=%b imemload=%h, expected 0 / 00000000 / 0 / 00000000",
                     iREN, iaddr, ihit, imemload);
        end
        @(negedge CLK);
        nRST = 1'b1;
        step(1'b1, 32'h0, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_0_miss: ihit=%b, expected 0", ihit);
        end
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h18, 1'b0);
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_partial: ihit=%b, expected 0", ihit);
        end
        step(1'b1, 32'h18, 1'b0);
        step(1'b1, 32'h18, 1'b0);
        step(1'b1, 32'h18, 1'b0);
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE_0018) begin
            tests_failed++;
            $display("FAIL rst_18_refill: ihit=%b imemload=%h, expected 1 / c0de0018", ihit, imemload);
        end
    endtask

    task automatic test_hit_sweep;
        logic [31:0] a;
        logic [31:0] exp_word;
        for (int s = 0; s < 8; s++) begin
            a = 32'(s * 8);
            step(1'b1, a, 1'b0);
            if (ihit !== 1'b1) begin
                step(1'b1, a, 1'b0);
                step(1'b1, a, 1'b0);
            end
        end
        for (int i = 0; i < 16; i++) begin
            a = 32'(i * 4);
            exp_word = mem_data(a);
            step(1'b1, a, 1'b0);
            tests_run++;
            if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== exp_word) begin
                tests_failed++;
                $display("FAIL sweep_%h: ihit=%b iREN=%b imemload=%h, expected 1 / 0 / %h",
                         a, ihit, iREN, imemload, exp_word);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b0;
        #12;
        test_reset;
        test_cold_miss;
        test_wait_states;
        test_conflict;
        test_addr_change;
        test_reset_mid_fill;
        test_hit_sweep;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
